framebuffer_capture_dbuf: RTL and testbench
===========================================

Name: framebuffer_capture_dbuf

Overview:
Synthesizable, double-buffered successor to the dummy frame buffer in the pGB simulation bench. It captures GPU frame-buffer word writes into one bank while the other, completed bank streams out as unpacked pixels over a valid/ready interface. It sits between pGB's oFrameBuffer* outputs and the LCD/scan-out or bench-dump logic. Width, depth, pixel size and line length are parametrised.

Parameters:
DATA_W, 16, frame-buffer word width
ADDR_W, 13, word address width; each bank holds 2**ADDR_W words
PIX_W, 2, bits per pixel; DATA_W % PIX_W == 0; WORD_PIX = DATA_W/PIX_W
LAST_ADDR, 2**ADDR_W-1, word address whose write marks end of frame
LINE_WORDS, 32, words per display line, used for oLineEnd

Ports:
iClock  in  1  clock
iReset  in  1  synchronous, active-high reset
iFrameBufferWe  in  1  GPU write strobe
iFrameBufferAddr  in  ADDR_W  GPU word address
iFrameBufferData  in  DATA_W  GPU word data
oFrameDone  out  1  one-cycle pulse: frame completed
oFrameCount  out  16  completed-frame counter, wraps
iReadStart  in  1  request readout of pending frame
oPixel  out  PIX_W  current pixel
oPixelValid  out  1  pixel valid
iPixelReady  in  1  sink ready
oPixelLast  out  1  last pixel of frame (qualified by valid)
oLineEnd  out  1  last pixel of a line (qualified by valid)
oBusy  out  1  readout in progress
oPending  out  1  completed frame waiting for readout
oOverrun  out  1  sticky: a frame was dropped

Behaviour:
- Reset values:
  - All outputs 0.
  - Write bank = 0, read bank = 1, pending = 0.
  - Read FSM = IDLE.
  - Reset mid-readout aborts the stream immediately; no partial flush.
- Write path:
  - While iFrameBufferWe is high, mem[wbank][addr] <= data on that edge.
  - Writes with addr > LAST_ADDR are ignored.
  - No backpressure toward the GPU.
- End of frame: a write to LAST_ADDR completes the frame.
  - Next cycle: oFrameDone = 1 for exactly one cycle; oFrameCount increments (0xFFFF -> 0x0000).
  - If the FSM is IDLE, or is finishing its final handshake in the same cycle: swap banks, set pending.
  - Otherwise (busy): no swap, set oOverrun, keep pending unchanged. The next frame overwrites the same write bank.
- Start:
  - iReadStart is accepted only in IDLE with pending = 1. On accept: clear pending, clear oOverrun, word pointer = 0, go to READ.
  - iReadStart is ignored when pending = 0 or when busy.
- Read FSM (synchronous RAM, 1-cycle read latency):
  - IDLE: oBusy = 0.
  - READ: drive mem[rbank][ptr]; next state LOAD.
  - LOAD: shift register <= RAM data, pixel index = 0; next state EMIT.
  - EMIT: oPixelValid = 1, oPixel = top PIX_W bits of the shift register, so pixel 0 = bits [DATA_W-1:DATA_W-PIX_W].
    - On valid & ready: shift left by PIX_W, increment pixel index.
    - After the WORD_PIX-th handshake: if ptr == LAST_ADDR go to IDLE, else ptr++ and go to READ.
  - oBusy = 1 in READ, LOAD and EMIT.
  - oPixel, oPixelLast and oLineEnd hold stable while valid & !ready.
- oLineEnd = 1 on the last pixel of a word where (ptr+1) % LINE_WORDS == 0.
- oPixelLast = 1 on the last pixel of word LAST_ADDR.
- Throughput: WORD_PIX + 2 cycles per word at ready = 1.
- Same-bank conflict is impossible: the write and read banks always differ.
- Writes arriving during readout always target the write bank.

Optional Feature:
FRAMEBUFFER_CRC_EN
- Defined:
  - Adds port oFrameCrc (out, 16 bits): CRC-16-CCITT (polynomial 0x1021, init 0xFFFF).
  - The CRC is computed over the emitted pixels, PIX_W bits per handshake, MSB first.
  - It is latched on the oPixelLast handshake and reset to 0x0000 by iReset.
- Undefined:
  - The port is absent and there is no CRC logic. All other behaviour is identical.

Test Plan:
1. Reset, then write words 0..8191 with data = addr[15:0], then iReadStart.
   - oFrameDone pulses once; oFrameCount = 1.
   - Stream word 0x0005 yields pixels 0,0,0,0,0,0,1,1.
   - 65536 pixels total; oPixelLast appears only on the final pixel.
2. Hold iPixelReady low for 3 cycles during EMIT.
   - oPixel and oPixelValid are held; no pixel is lost or duplicated.
   - oLineEnd is seen on pixels 255, 511, ...
3. Complete frame A, start readout, then complete frame B during readout.
   - oOverrun = 1, oPending stays 0, no swap.
   - After readout completes, a third frame C swaps normally and oPending = 1.
4. Issue the final ready handshake and a write to LAST_ADDR in the same cycle.
   - Swap occurs, oPending = 1, oOverrun = 0.
5. Assert iReset in EMIT mid-word.
   - Next cycle all outputs are 0 and the FSM is IDLE.
   - iReadStart is then ignored because pending = 0.
6. Small configuration (ADDR_W=2, DATA_W=8, PIX_W=2, LINE_WORDS=2, FRAMEBUFFER_CRC_EN defined), frame all 0xFF.
   - 16 pixels of value 3 emitted.
   - oFrameCrc equals the model CRC of 32 one-bits.

Source files
------------

// File: rtl/framebuffer_capture_dbuf.sv
// Double-buffered frame-buffer capture with a valid/ready pixel readout stream.
// Defining FRAMEBUFFER_CRC_EN adds oFrameCrc, a CRC-16-CCITT of each emitted frame.
module framebuffer_capture_dbuf #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned ADDR_W     = 13,
  parameter int unsigned PIX_W      = 2,
  parameter int unsigned LAST_ADDR  = 2**ADDR_W - 1,
  parameter int unsigned LINE_WORDS = 32
) (
  input  logic              iClock,
  input  logic              iReset,
  input  logic              iFrameBufferWe,
  input  logic [ADDR_W-1:0] iFrameBufferAddr,
  input  logic [DATA_W-1:0] iFrameBufferData,
  output logic              oFrameDone,
  output logic [15:0]       oFrameCount,
  input  logic              iReadStart,
  output logic [PIX_W-1:0]  oPixel,
  output logic              oPixelValid,
  input  logic              iPixelReady,
  output logic              oPixelLast,
  output logic              oLineEnd,
  output logic              oBusy,
  output logic              oPending,
  output logic              oOverrun
`ifdef FRAMEBUFFER_CRC_EN
  ,
  output logic [15:0]       oFrameCrc
`endif
);

  localparam int unsigned WORD_PIX  = DATA_W / PIX_W;
  localparam int unsigned PIX_IDX_W = (WORD_PIX > 1) ? $clog2(WORD_PIX) : 1;
  localparam int unsigned LINE_W    = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam logic [ADDR_W-1:0]    LAST      = ADDR_W'(LAST_ADDR);
  localparam logic [PIX_IDX_W-1:0] PIX_LAST  = PIX_IDX_W'(WORD_PIX - 1);
  localparam logic [LINE_W-1:0]    LINE_LAST = LINE_W'(LINE_WORDS - 1);

  typedef enum logic [1:0] {IDLE, READ, LOAD, EMIT} state_t;

  state_t                state;
  logic                  wbank;
  logic [ADDR_W-1:0]     ptr;
  logic [PIX_IDX_W-1:0]  pix_idx;
  logic [LINE_W-1:0]     line_cnt;
  logic [DATA_W-1:0]     shreg;
  logic [DATA_W-1:0]     rdata;
  logic                  pending;
  logic                  overrun;
  logic                  done;
  logic [15:0]           count;

  logic in_range;
  logic wr_en;
  logic eof;
  logic hs;
  logic word_done;
  logic final_hs;
  logic start_ok;
  logic swap;

  // Bank index is the top address bit; the read bank is always the other one.
  logic [DATA_W-1:0] mem [2**(ADDR_W+1)];

  generate
    if (LAST_ADDR >= 2**ADDR_W - 1) begin : g_full_range
      assign in_range = 1'b1;
    end else begin : g_part_range
      assign in_range = (iFrameBufferAddr <= LAST);
    end
  endgenerate

  always_comb begin
    wr_en     = iFrameBufferWe && in_range;
    eof       = wr_en && (iFrameBufferAddr == LAST);
    hs        = (state == EMIT) && iPixelReady;
    word_done = hs && (pix_idx == PIX_LAST);
    final_hs  = word_done && (ptr == LAST);
    start_ok  = (state == IDLE) && pending && iReadStart;
    swap      = eof && ((state == IDLE) || final_hs);
  end

  always_ff @(posedge iClock) begin
    if (wr_en) mem[{wbank, iFrameBufferAddr}] <= iFrameBufferData;
    rdata <= mem[{~wbank, ptr}];
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      state    <= IDLE;
      wbank    <= 1'b0;
      ptr      <= '0;
      pix_idx  <= '0;
      line_cnt <= '0;
      shreg    <= '0;
      pending  <= 1'b0;
      overrun  <= 1'b0;
      done     <= 1'b0;
      count    <= '0;
    end else begin
      done <= eof;
      if (eof) begin
        count <= count + 16'd1;
        if (swap) begin
          wbank   <= ~wbank;
          pending <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end
      case (state)
        IDLE: begin
          if (start_ok) begin
            // A frame landing on the same edge is the one read next, so pending still clears.
            pending  <= 1'b0;
            overrun  <= 1'b0;
            ptr      <= '0;
            line_cnt <= '0;
            state    <= READ;
          end
        end
        READ: state <= LOAD;
        LOAD: begin
          shreg   <= rdata;
          pix_idx <= '0;
          state   <= EMIT;
        end
        EMIT: begin
          if (hs) begin
            shreg   <= shreg << PIX_W;
            pix_idx <= pix_idx + 1'b1;
            if (word_done) begin
              line_cnt <= (line_cnt == LINE_LAST) ? '0 : line_cnt + 1'b1;
              if (ptr == LAST) begin
                state <= IDLE;
              end else begin
                ptr   <= ptr + 1'b1;
                state <= READ;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign oFrameDone  = done;
  assign oFrameCount = count;
  assign oBusy       = (state != IDLE);
  assign oPixelValid = (state == EMIT);
  assign oPixel      = (state == EMIT) ? shreg[DATA_W-1 -: PIX_W] : '0;
  assign oPixelLast  = (state == EMIT) && (pix_idx == PIX_LAST) && (ptr == LAST);
  assign oLineEnd    = (state == EMIT) && (pix_idx == PIX_LAST) && (line_cnt == LINE_LAST);
  assign oPending    = pending;
  assign oOverrun    = overrun;

`ifdef FRAMEBUFFER_CRC_EN
  logic [15:0] crc;
  logic [15:0] crc_next;

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [PIX_W-1:0] p);
    logic [15:0] r;
    logic        fb;
    r = c;
    for (int unsigned i = 0; i < PIX_W; i++) begin
      fb = r[15] ^ p[PIX_W-1-i];
      r  = {r[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end
    return r;
  endfunction

  assign crc_next = crc_step(crc, oPixel);

  always_ff @(posedge iClock) begin
    if (iReset) begin
      crc       <= 16'hFFFF;
      oFrameCrc <= '0;
    end else begin
      if (start_ok) crc <= 16'hFFFF;
      else if (hs)  crc <= crc_next;
      if (hs && oPixelLast) oFrameCrc <= crc_next;
    end
  end
`endif

endmodule

// File: tb/tb_framebuffer_capture_dbuf.sv
// Randomized bench for framebuffer_capture_dbuf: a 64-word main instance and a 4-word instance.
module tb_framebuffer_capture_dbuf;

  typedef logic [15:0] frame_t [64];

  logic        clk;
  logic        rst;
  logic        we;
  logic [5:0]  addr;
  logic [15:0] data;
  logic        done;
  logic [15:0] cnt;
  logic        start;
  logic [1:0]  pix;
  logic        valid;
  logic        ready;
  logic        last;
  logic        le;
  logic        busy;
  logic        pending;
  logic        overrun;

  logic        s_we;
  logic [1:0]  s_addr;
  logic [7:0]  s_data;
  logic        s_done;
  logic [15:0] s_cnt;
  logic        s_start;
  logic [1:0]  s_pix;
  logic        s_valid;
  logic        s_ready;
  logic        s_last;
  logic        s_le;
  logic        s_busy;
  logic        s_pending;
  logic        s_overrun;
`ifdef FRAMEBUFFER_CRC_EN
  logic [15:0] crc;
  logic [15:0] s_crc;
`endif

  int unsigned errors = 0;
  int unsigned checks = 0;
  int unsigned model_count;
  logic [1:0]  got_pix[$];
  logic        got_last[$];
  logic        got_le[$];
  logic [3:0]  bad_got;
  logic [3:0]  bad_exp;

  framebuffer_capture_dbuf #(.DATA_W(16), .ADDR_W(6), .PIX_W(2), .LAST_ADDR(63), .LINE_WORDS(32)) dut (
    .iClock(clk), .iReset(rst), .iFrameBufferWe(we), .iFrameBufferAddr(addr),
    .iFrameBufferData(data), .oFrameDone(done), .oFrameCount(cnt), .iReadStart(start),
    .oPixel(pix), .oPixelValid(valid), .iPixelReady(ready), .oPixelLast(last),
    .oLineEnd(le), .oBusy(busy), .oPending(pending), .oOverrun(overrun)
`ifdef FRAMEBUFFER_CRC_EN
    , .oFrameCrc(crc)
`endif
  );

  framebuffer_capture_dbuf #(.DATA_W(8), .ADDR_W(2), .PIX_W(2), .LAST_ADDR(3), .LINE_WORDS(2)) dut_small (
    .iClock(clk), .iReset(rst), .iFrameBufferWe(s_we), .iFrameBufferAddr(s_addr),
    .iFrameBufferData(s_data), .oFrameDone(s_done), .oFrameCount(s_cnt), .iReadStart(s_start),
    .oPixel(s_pix), .oPixelValid(s_valid), .iPixelReady(s_ready), .oPixelLast(s_last),
    .oLineEnd(s_le), .oBusy(s_busy), .oPending(s_pending), .oOverrun(s_overrun)
`ifdef FRAMEBUFFER_CRC_EN
    , .oFrameCrc(s_crc)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Pixel i of a frame: word i/8, pixels taken MSB first.
  function automatic logic [1:0] exp_pixel(input frame_t f, input int unsigned i);
    logic [15:0] w;
    int unsigned k;
    w = f[i / 8];
    k = i % 8;
    return 2'((w >> (14 - 2 * k)) & 16'h3);
  endfunction

  function automatic logic exp_line_end(input int unsigned i);
    return (((i / 8) + 1) % 32 == 0) && (i % 8 == 7);
  endfunction

  function automatic logic [15:0] crc_bit(input logic [15:0] c, input logic b);
    return (c[15] ^ b) ? ({c[14:0], 1'b0} ^ 16'h1021) : {c[14:0], 1'b0};
  endfunction

  task automatic rand_frame(output frame_t f);
    for (int i = 0; i < 64; i++) f[i] = 16'($urandom);
  endtask

  task automatic write_frame(input frame_t f, input int unsigned nw, output logic d, output logic [15:0] c);
    for (int unsigned a = 0; a < nw; a++) begin
      @(negedge clk);
      we = 1'b1;
      addr = 6'(a);
      data = f[a];
    end
    @(negedge clk);
    we = 1'b0;
    d = done;
    c = cnt;
  endtask

  task automatic start_read();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic read_frame(input frame_t f, input int unsigned pct, input bit stop_at_last,
                            output int unsigned n, output int first_bad,
                            output int unsigned unstable, output bit timeout);
    bit          held;
    bit          take;
    logic [3:0]  hv;
    logic [3:0]  cur;
    logic [3:0]  ex;
    int unsigned lows;
    got_pix.delete();
    got_last.delete();
    got_le.delete();
    n = 0; first_bad = -1; unstable = 0; timeout = 1'b1; held = 1'b0; lows = 0; hv = '0;
    for (int unsigned cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      cur = {pix, last, le};
      if (held && !(valid && cur == hv)) unstable++;
      if (stop_at_last && valid && last) begin
        take = 1'b1;
      end else begin
        if (pct >= 100) ready = 1'b1;
        else if (n == 5 && lows < 3) begin ready = 1'b0; lows++; end
        else ready = ($urandom_range(99, 0) < pct);
        take = valid && ready;
      end
      held = valid && !ready;
      hv = cur;
      if (take) begin
        ex = {exp_pixel(f, n), n == 511, exp_line_end(n)};
        if (cur !== ex && first_bad < 0) begin
          first_bad = n; bad_got = cur; bad_exp = ex;
        end
        got_pix.push_back(pix);
        got_last.push_back(last);
        got_le.push_back(le);
        n++;
        if (last || n >= 512) begin timeout = 1'b0; break; end
      end
    end
    if (!stop_at_last) begin
      @(negedge clk);
      ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; we = 1'b0; addr = '0; data = '0; start = 1'b0; ready = 1'b0;
    s_we = 1'b0; s_addr = '0; s_data = '0; s_start = 1'b0; s_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_count = 0;
    checks++;
    if ({done, cnt, pix, valid, last, le, busy, pending, overrun} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got=%h exp=0", {done, cnt, pix, valid, last, le, busy, pending, overrun});
    end
`ifdef FRAMEBUFFER_CRC_EN
    checks++;
    if (crc !== 16'h0000) begin errors++; $display("FAIL reset_crc got=%h exp=0000", crc); end
`endif
    start_read();
    checks++;
    if (busy !== 1'b0 || valid !== 1'b0) begin
      errors++; $display("FAIL reset_start_ignored busy=%b valid=%b exp=0,0", busy, valid);
    end
  endtask

  task automatic test_stream();
    frame_t      f;
    logic        d;
    logic [15:0] c;
    logic [15:0] w5;
    int unsigned n, unst, nl;
    int          fb;
    bit          to;
    for (int i = 0; i < 64; i++) f[i] = 16'(i);
    write_frame(f, 64, d, c);
    model_count++;
    checks++;
    if (d !== 1'b1) begin errors++; $display("FAIL t1_done got=%b exp=1", d); end
    checks++;
    if (c !== 16'(model_count)) begin errors++; $display("FAIL t1_count got=%0d exp=%0d", c, model_count); end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || pending !== 1'b1) begin
      errors++; $display("FAIL t1_after_done done=%b pending=%b exp=0,1", done, pending);
    end
    start_read();
    checks++;
    if (busy !== 1'b1 || pending !== 1'b0) begin
      errors++; $display("FAIL t1_start busy=%b pending=%b exp=1,0", busy, pending);
    end
    read_frame(f, 100, 1'b0, n, fb, unst, to);
    checks++;
    if (n !== 512 || to) begin errors++; $display("FAIL t1_pixel_count got=%0d exp=512 timeout=%b", n, to); end
    checks++;
    if (fb != -1) begin
      errors++; $display("FAIL t1_stream at=%0d got={pix,last,le}=%b exp=%b", fb, bad_got, bad_exp);
    end
    w5 = '1;
    if (n >= 48) for (int k = 0; k < 8; k++) w5 = {w5[13:0], got_pix[40 + k]};
    checks++;
    if (w5 !== 16'h0005) begin errors++; $display("FAIL t1_word5 got=%h exp=0005", w5); end
    nl = 0;
    for (int i = 0; i < got_last.size(); i++) if (got_last[i]) nl++;
    checks++;
    if (nl !== 1) begin errors++; $display("FAIL t1_last_count got=%0d exp=1", nl); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL t1_idle_after busy=%b exp=0", busy); end
`ifdef FRAMEBUFFER_CRC_EN
    begin
      logic [15:0] mc;
      mc = 16'hFFFF;
      for (int w = 0; w < 64; w++)
        for (int b = 15; b >= 0; b--) mc = crc_bit(mc, f[w][b]);
      checks++;
      if (crc !== mc) begin errors++; $display("FAIL t1_crc got=%h exp=%h", crc, mc); end
    end
`endif
  endtask

  task automatic test_backpressure();
    frame_t      f;
    logic        d;
    logic [15:0] c;
    int unsigned n, unst, nle;
    int          fb;
    bit          to;
    rand_frame(f);
    write_frame(f, 64, d, c);
    model_count++;
    checks++;
    if (d !== 1'b1 || c !== 16'(model_count)) begin
      errors++; $display("FAIL t2_done done=%b count=%0d exp=1,%0d", d, c, model_count);
    end
    start_read();
    read_frame(f, 60, 1'b0, n, fb, unst, to);
    checks++;
    if (n !== 512 || to) begin errors++; $display("FAIL t2_pixel_count got=%0d exp=512 timeout=%b", n, to); end
    checks++;
    if (fb != -1) begin
      errors++; $display("FAIL t2_stream at=%0d got={pix,last,le}=%b exp=%b", fb, bad_got, bad_exp);
    end
    checks++;
    if (unst !== 0) begin errors++; $display("FAIL t2_hold_stable violations=%0d exp=0", unst); end
    nle = 0;
    for (int i = 0; i < got_le.size(); i++) if (got_le[i]) nle++;
    checks++;
    if (nle !== 2 || n < 512 || !got_le[255] || !got_le[511]) begin
      errors++; $display("FAIL t2_line_end count=%0d exp=2 at 255,511", nle);
    end
  endtask

  task automatic test_overrun();
    frame_t      a, b, c3;
    logic        d, db;
    logic [15:0] c, cb;
    int unsigned n, unst;
    int          fb;
    bit          to;
    rand_frame(a); rand_frame(b); rand_frame(c3);
    write_frame(a, 64, d, c);
    model_count++;
    checks++;
    if (pending !== 1'b1) begin errors++; $display("FAIL t3_pending_a got=%b exp=1", pending); end
    start_read();
    fork
      write_frame(b, 64, db, cb);
      read_frame(a, 100, 1'b0, n, fb, unst, to);
    join
    model_count++;
    checks++;
    if (db !== 1'b1 || cb !== 16'(model_count)) begin
      errors++; $display("FAIL t3_done_b done=%b count=%0d exp=1,%0d", db, cb, model_count);
    end
    checks++;
    if (overrun !== 1'b1 || pending !== 1'b0) begin
      errors++; $display("FAIL t3_overrun overrun=%b pending=%b exp=1,0", overrun, pending);
    end
    checks++;
    if (n !== 512 || to || fb != -1) begin
      errors++; $display("FAIL t3_stream_a n=%0d bad_at=%0d got=%b exp=%b", n, fb, bad_got, bad_exp);
    end
    write_frame(c3, 64, d, c);
    model_count++;
    checks++;
    if (pending !== 1'b1 || overrun !== 1'b1) begin
      errors++; $display("FAIL t3_frame_c pending=%b overrun=%b exp=1,1", pending, overrun);
    end
    start_read();
    checks++;
    if (overrun !== 1'b0) begin errors++; $display("FAIL t3_overrun_clear got=%b exp=0", overrun); end
    read_frame(c3, 80, 1'b0, n, fb, unst, to);
    checks++;
    if (n !== 512 || to || fb != -1) begin
      errors++; $display("FAIL t3_stream_c n=%0d bad_at=%0d got=%b exp=%b", n, fb, bad_got, bad_exp);
    end
  endtask

  task automatic test_simultaneous();
    frame_t      x, e;
    logic        d;
    logic [15:0] c;
    int unsigned n, unst;
    int          fb;
    bit          to;
    rand_frame(x); rand_frame(e);
    write_frame(x, 64, d, c);
    model_count++;
    start_read();
    write_frame(e, 63, d, c);
    read_frame(x, 100, 1'b1, n, fb, unst, to);
    ready = 1'b1; we = 1'b1; addr = 6'd63; data = e[63];
    model_count++;
    @(negedge clk);
    we = 1'b0; ready = 1'b0;
    checks++;
    if (n !== 512 || to || fb != -1 || unst !== 0) begin
      errors++; $display("FAIL t4_stream_x n=%0d bad_at=%0d got=%b exp=%b", n, fb, bad_got, bad_exp);
    end
    checks++;
    if ({done, pending, overrun, busy} !== 4'b1100) begin
      errors++; $display("FAIL t4_swap {done,pending,overrun,busy}=%b exp=1100", {done, pending, overrun, busy});
    end
    checks++;
    if (cnt !== 16'(model_count)) begin errors++; $display("FAIL t4_count got=%0d exp=%0d", cnt, model_count); end
    start_read();
    read_frame(e, 100, 1'b0, n, fb, unst, to);
    checks++;
    if (n !== 512 || to || fb != -1) begin
      errors++; $display("FAIL t4_stream_e n=%0d bad_at=%0d got=%b exp=%b", n, fb, bad_got, bad_exp);
    end
  endtask

  task automatic test_reset_mid();
    frame_t      f;
    logic        d;
    logic [15:0] c;
    int unsigned got;
    rand_frame(f);
    write_frame(f, 64, d, c);
    start_read();
    ready = 1'b1;
    got = 0;
    for (int cyc = 0; cyc < 100 && got < 3; cyc++) begin
      @(negedge clk);
      if (valid) got++;
    end
    @(negedge clk);
    checks++;
    if (valid !== 1'b1 || got !== 3) begin
      errors++; $display("FAIL t5_pre_valid valid=%b handshakes=%0d exp=1,3", valid, got);
    end
    rst = 1'b1; ready = 1'b0;
    @(negedge clk);
    checks++;
    if ({done, cnt, pix, valid, last, le, busy, pending, overrun} !== '0) begin
      errors++;
      $display("FAIL t5_reset_outputs got=%h exp=0", {done, cnt, pix, valid, last, le, busy, pending, overrun});
    end
`ifdef FRAMEBUFFER_CRC_EN
    checks++;
    if (crc !== 16'h0000) begin errors++; $display("FAIL t5_reset_crc got=%h exp=0000", crc); end
`endif
    rst = 1'b0;
    model_count = 0;
    start_read();
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || valid !== 1'b0 || pending !== 1'b0) begin
      errors++; $display("FAIL t5_start_ignored busy=%b valid=%b pending=%b exp=0,0,0", busy, valid, pending);
    end
  endtask

  task automatic test_small_crc();
    int unsigned n, badp, badl, badle;
    for (int a = 0; a < 4; a++) begin
      @(negedge clk);
      s_we = 1'b1; s_addr = 2'(a); s_data = 8'hFF;
    end
    @(negedge clk);
    s_we = 1'b0;
    checks++;
    if (s_done !== 1'b1 || s_pending !== 1'b1) begin
      errors++; $display("FAIL t6_done done=%b pending=%b exp=1,1", s_done, s_pending);
    end
    @(negedge clk); s_start = 1'b1;
    @(negedge clk); s_start = 1'b0;
    s_ready = 1'b1;
    n = 0; badp = 0; badl = 0; badle = 0;
    for (int cyc = 0; cyc < 200 && n < 16; cyc++) begin
      @(negedge clk);
      if (s_valid) begin
        if (s_pix !== 2'd3) badp++;
        if (s_last !== (n == 15)) badl++;
        if (s_le !== ((n % 4 == 3) && ((n / 4 + 1) % 2 == 0))) badle++;
        n++;
      end
    end
    @(negedge clk);
    s_ready = 1'b0;
    checks++;
    if (n !== 16 || s_busy !== 1'b0) begin
      errors++; $display("FAIL t6_pixel_count got=%0d busy=%b exp=16,0", n, s_busy);
    end
    checks++;
    if (badp !== 0 || badl !== 0 || badle !== 0) begin
      errors++; $display("FAIL t6_stream bad_pix=%0d bad_last=%0d bad_le=%0d exp=0,0,0", badp, badl, badle);
    end
`ifdef FRAMEBUFFER_CRC_EN
    begin
      logic [15:0] mc;
      mc = 16'hFFFF;
      for (int i = 0; i < 32; i++) mc = crc_bit(mc, 1'b1);
      checks++;
      if (s_crc !== mc) begin errors++; $display("FAIL t6_crc got=%h exp=%h", s_crc, mc); end
    end
`endif
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_overrun();
    test_simultaneous();
    test_reset_mid();
    test_small_crc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
